// File: rtl/l2_arb_pkg.sv
// Shared encodings for the I/D-side L2 arbiter: FSM states, owner ids and
// operation codes, plus the read-wins operation decode.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Only consulted for a side that is requesting, so read low implies write.
    function automatic op_t decode_op(input logic read);
        return read ? OP_RD : OP_WR;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a tie goes to whichever side was not granted last time.
module rr_pick2
    import l2_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic       gnt_valid,
    output owner_t     gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = OWN_I;
        if (req == 2'b11) begin
            gnt_id = (last == OWN_I) ? OWN_D : OWN_I;
        end else if (req[1]) begin
            gnt_id = OWN_D;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 between the instruction and data L1s,
// one transaction at a time. Define L2_ARB_STATS_EN for grant/conflict counters.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_stall,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,

    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_ready,
    input  logic              l2_stall
);

    arb_state_t        state;
    arb_state_t        next_state;
    owner_t            owner_q;
    owner_t            last_grant;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic   i_req;
    logic   d_req;
    logic   gnt_valid;
    owner_t gnt_id;
    logic   grant;
    logic   l2_stall_unused;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    // Sequencing relies solely on l2_ready; the busy flag carries no extra information.
    assign l2_stall_unused = l2_stall;

    rr_pick2 u_pick (
        .req       ({d_req, i_req}),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign grant = (state == IDLE) && gnt_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (gnt_valid) next_state = BUSY;
            BUSY:    if (l2_ready)  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields are latched at grant so L2 sees a stable request even if
    // the requester misbehaves; read data lands in the owner's return register.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_I;
            last_grant <= OWN_D;
            op_q       <= OP_RD;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (grant) begin
                owner_q    <= gnt_id;
                last_grant <= gnt_id;
                if (gnt_id == OWN_I) begin
                    op_q    <= decode_op(i_read);
                    addr_q  <= i_addr;
                    wdata_q <= i_wdata;
                end else begin
                    op_q    <= decode_op(d_read);
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                end
            end
            if ((state == BUSY) && l2_ready && (op_q == OP_RD)) begin
                if (owner_q == OWN_I) begin
                    i_rdata <= l2_rdata;
                end else begin
                    d_rdata <= l2_rdata;
                end
            end
        end
    end

    // The request is dropped in the l2_ready cycle so L2 cannot re-sample it
    // as it returns to idle.
    always_comb begin
        l2_read  = (state == BUSY) && (op_q == OP_RD) && !l2_ready;
        l2_write = (state == BUSY) && (op_q == OP_WR) && !l2_ready;
        i_ready  = (state == RESP) && (owner_q == OWN_I);
        d_ready  = (state == RESP) && (owner_q == OWN_D);
        i_stall  = i_req && !i_ready;
        d_stall  = d_req && !d_ready;
    end

    assign l2_addr  = addr_q;
    assign l2_wdata = wdata_q;

`ifdef L2_ARB_STATS_EN
    logic [15:0] i_grant_cnt;
    logic [15:0] d_grant_cnt;
    logic [15:0] conflict_cnt;
    logic [15:0] i_grant_nxt;
    logic [15:0] d_grant_nxt;
    logic [15:0] conflict_nxt;

    always_comb begin
        i_grant_nxt  = i_grant_cnt  + {15'd0, gnt_id == OWN_I};
        d_grant_nxt  = d_grant_cnt  + {15'd0, gnt_id == OWN_D};
        conflict_nxt = conflict_cnt + {15'd0, i_req & d_req};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_grant_cnt  <= '0;
            d_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else if (grant) begin
            i_grant_cnt  <= i_grant_nxt;
            d_grant_cnt  <= d_grant_nxt;
            conflict_cnt <= conflict_nxt;
            $display("L2ARB : I/D/conflict = %d/%d/%d", i_grant_nxt, d_grant_nxt, conflict_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: a transaction-level model checked every
// cycle, a small L2 responder, and directed scenarios with literal expectations.
module tb_l2_arbiter;

    localparam int AW = 30;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_read = 1'b0, i_write = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_wdata = '0;
    logic [LW-1:0] i_rdata;
    logic          i_ready, i_stall;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_ready, d_stall;
    logic          l2_read, l2_write;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] l2_rdata = '0;
    logic          l2_ready = 1'b0;
    logic          l2_stall = 1'b0;

    l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_stall(l2_stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // L2 responder: pulses l2_ready once the request has been seen for lat cycles.
    int lat = 1;
    int l2_cnt = 0;
    bit inject = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            l2_ready <= 1'b0;
            l2_cnt   <= 0;
        end else if (l2_ready) begin
            l2_ready <= 1'b0;
            l2_cnt   <= 0;
        end else if (inject) begin
            l2_ready <= 1'b1;
        end else if (l2_read || l2_write) begin
            if (l2_cnt + 1 >= lat) begin
                l2_ready <= 1'b1;
                l2_cnt   <= 0;
            end else begin
                l2_cnt <= l2_cnt + 1;
            end
        end
    end

    // Transaction-level model: one in-flight record plus a one-cycle response flag.
    bit            m_busy, m_resp, m_owner_d, m_wr, m_last_d;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_i_rdata, m_d_rdata;
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_resp = 0; m_owner_d = 0; m_wr = 0; m_last_d = 1;
            m_addr = '0; m_wdata = '0; m_i_rdata = '0; m_d_rdata = '0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (l2_ready) begin
                m_busy = 0;
                m_resp = 1;
                if (!m_wr) begin
                    if (m_owner_d) m_d_rdata = l2_rdata;
                    else           m_i_rdata = l2_rdata;
                end
            end
        end else if ((i_read | i_write) || (d_read | d_write)) begin
            if ((i_read | i_write) && (d_read | d_write)) m_owner_d = !m_last_d;
            else                                          m_owner_d = d_read | d_write;
            m_wr     = m_owner_d ? !d_read : !i_read;
            m_addr   = m_owner_d ? d_addr  : i_addr;
            m_wdata  = m_owner_d ? d_wdata : i_wdata;
            m_last_d = m_owner_d;
            m_busy   = 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("l2_read",  128'(l2_read),  128'(m_busy && !m_wr && !l2_ready));
            checkOutput("l2_write", 128'(l2_write), 128'(m_busy && m_wr && !l2_ready));
            checkOutput("l2_addr",  128'(l2_addr),  128'(m_addr));
            checkOutput("l2_wdata", l2_wdata, m_wdata);
            checkOutput("i_ready",  128'(i_ready),  128'(m_resp && !m_owner_d));
            checkOutput("d_ready",  128'(d_ready),  128'(m_resp && m_owner_d));
            checkOutput("i_rdata",  i_rdata, m_i_rdata);
            checkOutput("d_rdata",  d_rdata, m_d_rdata);
            checkOutput("i_stall",  128'(i_stall),  128'((i_read | i_write) && !(m_resp && !m_owner_d)));
            checkOutput("d_stall",  128'(d_stall),  128'((d_read | d_write) && !(m_resp && m_owner_d)));
        end
    end

    // Observation logs used by the directed scenarios.
    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } tx_t;
    tx_t tx_log[$];
    bit  ready_log[$];
    bit  prev_l2req = 1'b0;
    int  rd_cycles = 0;
    int  d_unstalled = 0;
    int  gate_viol = 0;
    always @(negedge clk) begin
        if (check_en) begin
            if ((l2_read | l2_write) && !prev_l2req) tx_log.push_back('{l2_write, l2_addr, l2_wdata});
            prev_l2req = l2_read | l2_write;
            if (l2_read) rd_cycles++;
            if ((d_read | d_write) && !d_stall && !d_ready) d_unstalled++;
            if (l2_ready && (l2_read | l2_write)) gate_viol++;
            if (i_ready) ready_log.push_back(1'b0);
            if (d_ready) ready_log.push_back(1'b1);
        end
    end

    function automatic int readyAt(input int i);
        if (i < ready_log.size()) return int'(ready_log[i]);
        return -1;
    endfunction

    task automatic applyStimulus(input bit side_d, input bit rd, input bit wr,
                                 input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
        if (side_d) begin
            d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
        end else begin
            i_read = rd; i_write = wr; i_addr = addr; i_wdata = wdata;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        tx_log.delete();
        ready_log.delete();
        rd_cycles = 0; d_unstalled = 0; gate_viol = 0;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        applyStimulus(0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Runs until the ready log holds target entries; drop releases a side's request after its pulse.
    task automatic runUntil(input string name, input int target, input int budget, input bit drop);
        int handled;
        handled = ready_log.size();
        for (int c = 0; c < budget && ready_log.size() < target; c++) begin
            @(posedge clk); #1;
            while (handled < ready_log.size()) begin
                if (drop) applyStimulus(ready_log[handled], 0, 0, '0, '0);
                handled++;
            end
        end
        checkOutput(name, 128'(ready_log.size()), 128'(target));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_en = 1'b1;

        @(negedge clk);
        checkOutput("reset l2_read",  128'(l2_read),  128'(0));
        checkOutput("reset l2_write", 128'(l2_write), 128'(0));
        checkOutput("reset l2_addr",  128'(l2_addr),  128'(0));
        checkOutput("reset i_rdata",  i_rdata, 128'(0));
        checkOutput("reset d_ready",  128'(d_ready),  128'(0));

        // Lone I-side read with a three-cycle L2.
        clearLogs();
        lat = 3;
        l2_rdata = {16{8'hA5}};
        @(posedge clk); #1;
        applyStimulus(0, 1, 0, 30'h0000100, '0);
        runUntil("t1 readies", 1, 40, 1);
        idleCycles(4);
        checkOutput("t1 l2_read cycles", 128'(rd_cycles), 128'(3));
        checkOutput("t1 single pulse", 128'(ready_log.size()), 128'(1));
        checkOutput("t1 pulse side", 128'(readyAt(0)), 128'(0));
        checkOutput("t1 i_rdata", i_rdata, {16{8'hA5}});
        checkOutput("t1 d_stall", 128'(d_stall), 128'(0));

        // Simultaneous I read and D write straight after reset: I wins the first tie.
        doReset();
        clearLogs();
        lat = 2;
        l2_rdata = 128'h0BAD;
        applyStimulus(0, 1, 0, 30'h10, '0);
        applyStimulus(1, 0, 1, 30'h20, 128'h1234);
        runUntil("t2 readies", 2, 60, 1);
        idleCycles(2);
        checkOutput("t2 first side", 128'(readyAt(0)), 128'(0));
        checkOutput("t2 second side", 128'(readyAt(1)), 128'(1));
        checkOutput("t2 tx count", 128'(tx_log.size()), 128'(2));
        if (tx_log.size() >= 2) begin
            checkOutput("t2 tx0 addr", 128'(tx_log[0].addr), 128'(30'h10));
            checkOutput("t2 tx0 op", 128'(tx_log[0].wr), 128'(0));
            checkOutput("t2 tx1 op", 128'(tx_log[1].wr), 128'(1));
            checkOutput("t2 tx1 addr", 128'(tx_log[1].addr), 128'(30'h20));
            checkOutput("t2 tx1 wdata", tx_log[1].wdata, 128'h1234);
        end
        checkOutput("t2 d unstalled", 128'(d_unstalled), 128'(0));
        checkOutput("t2 i_rdata", i_rdata, 128'h0BAD);

        // Both sides hold requests for six transactions: strict alternation from I.
        doReset();
        clearLogs();
        lat = 1;
        l2_rdata = 128'h77;
        applyStimulus(0, 1, 0, 30'h40, '0);
        applyStimulus(1, 1, 0, 30'h80, '0);
        runUntil("t3 readies", 6, 100, 0);
        applyStimulus(0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0);
        idleCycles(2);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("t3 grant %0d", k), 128'(readyAt(k)), 128'(k % 2));
        end
        checkOutput("t3 tx count", 128'(tx_log.size()), 128'(6));
        if (tx_log.size() >= 2) begin
            checkOutput("t3 tx1 addr", 128'(tx_log[1].addr), 128'(30'h80));
        end
`ifdef L2_ARB_STATS_EN
        checkOutput("t3 i_grant_cnt", 128'(dut.i_grant_cnt), 128'(3));
        checkOutput("t3 d_grant_cnt", 128'(dut.d_grant_cnt), 128'(3));
        checkOutput("t3 conflict_cnt>=5", 128'(dut.conflict_cnt >= 16'd5), 128'(1));
`endif

        // D write: request gated in the l2_ready cycle, one L2 transaction, d_rdata kept.
        clearLogs();
        lat = 2;
        l2_rdata = 128'hFEED_BEEF;
        applyStimulus(1, 0, 1, 30'h55, 128'hCAFE);
        runUntil("t4 readies", 1, 40, 1);
        idleCycles(5);
        checkOutput("t4 tx count", 128'(tx_log.size()), 128'(1));
        if (tx_log.size() >= 1) begin
            checkOutput("t4 tx op", 128'(tx_log[0].wr), 128'(1));
        end
        checkOutput("t4 gated in ready cycle", 128'(gate_viol), 128'(0));
        checkOutput("t4 d_rdata kept", d_rdata, 128'h77);

        // Reset while BUSY, then a late l2_ready in IDLE, then a fresh read.
        clearLogs();
        lat = 10;
        applyStimulus(0, 1, 0, 30'h200, '0);
        for (int c = 0; c < 10 && !l2_read; c++) @(negedge clk);
        checkOutput("t5 reached busy", 128'(l2_read), 128'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        applyStimulus(0, 0, 0, '0, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5 l2_read after reset", 128'(l2_read), 128'(0));
        checkOutput("t5 l2_write after reset", 128'(l2_write), 128'(0));
        @(posedge clk); #1;
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        idleCycles(4);
        checkOutput("t5 no ready pulse", 128'(ready_log.size()), 128'(0));
        lat = 1;
        l2_rdata = 128'h5A5A;
        applyStimulus(0, 1, 0, 30'h300, '0);
        runUntil("t5 fresh readies", 1, 30, 1);
        idleCycles(2);
        checkOutput("t5 i_rdata", i_rdata, 128'h5A5A);
        checkOutput("t5 tx count", 128'(tx_log.size()), 128'(2));
        if (tx_log.size() >= 2) begin
            checkOutput("t5 fresh addr", 128'(tx_log[1].addr), 128'(30'h300));
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
